// File: rtl/calc_pkg.sv
// Shared types for the calculator input sequencer.
// State encoding and small elaboration helpers.
package calc_pkg;

    typedef enum logic [1:0] {
        S_OPERAND = 2'd0,
        S_OPCODE  = 2'd1,
        S_SHOW    = 2'd2
    } seq_state_t;

    // Fourth encoding of the state register; never entered normally.
    localparam logic [1:0] S_ILLEGAL = 2'd3;

    // Width of the operand index: at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/calc_input_seq_show_timer.sv
// Result-phase dwell counter for the input sequencer.
// done pulses on the last cycle of a TICKS-long window.
module show_timer #(
    parameter int TICKS = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CW = (TICKS > 0) ? $clog2(TICKS + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt;

    // Count while enabled; a zero window keeps the counter parked at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (TICKS != 0)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done = (TICKS == 0) ? 1'b0 : (en && (cnt == LAST));

endmodule

// File: rtl/calc_input_seq.sv
// Operand/opcode entry sequencer for the calculator datapath.
// Captures NUM_OPS operands and an opcode, then shows the result.
module calc_input_seq
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_OPS    = 2,
    parameter int OPCODE_W   = 2,
    parameter int SHOW_TICKS = 0,
    localparam int IDX_W     = idx_width(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trans,
    input  logic                     back,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [OPCODE_W-1:0]      op_in,
    output logic [NUM_OPS*WIDTH-1:0] operands,
    output logic [OPCODE_W-1:0]      opcode,
    output logic [1:0]               state_o,
    output logic [IDX_W-1:0]         idx_o,
    output logic [NUM_OPS:0]         hold,
    output logic                     result_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    if (NUM_OPS < 1 || NUM_OPS > 4) begin : g_bad_num_ops
        $error("calc_input_seq: NUM_OPS must be within 1..4");
    end

    seq_state_t                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_OPS*WIDTH-1:0]   ops_q, ops_d;
    logic [OPCODE_W-1:0]        opc_q, opc_d;
    logic [NUM_OPS:0]           hold_q, hold_d;
    logic                       rv_q, rv_d;
    logic                       wipe;
    logic                       tmr_en, tmr_clr, tmr_done;

    // The timer runs only while showing and restarts on any exit.
    assign tmr_en  = (state_q == S_SHOW);
    assign tmr_clr = ~tmr_en | trans | back | tmr_done;

    show_timer #(
        .TICKS (SHOW_TICKS)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .done (tmr_done)
    );

    // State and capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_OPERAND;
            idx_q   <= '0;
            ops_q   <= '0;
            opc_q   <= '0;
            hold_q  <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ops_q   <= ops_d;
            opc_q   <= opc_d;
            hold_q  <= hold_d;
            rv_q    <= rv_d;
        end
    end

    // Next-state and capture logic; back always beats trans.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ops_d   = ops_q;
        opc_d   = opc_q;
        hold_d  = hold_q;
        rv_d    = rv_q;
        wipe    = 1'b0;
        case (state_q)
            S_OPERAND: begin
                if (back) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                        for (int k = 0; k < NUM_OPS; k++) begin
                            if (IDX_W'(k + 1) == idx_q) begin
                                hold_d[k] = 1'b0;
                                ops_d[k*WIDTH +: WIDTH] = '0;
                            end
                        end
                    end
                end else if (trans) begin
                    for (int k = 0; k < NUM_OPS; k++) begin
                        if (IDX_W'(k) == idx_q) begin
                            hold_d[k] = 1'b1;
                            ops_d[k*WIDTH +: WIDTH] = data_in;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_OPCODE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_OPCODE: begin
                if (back) begin
                    state_d = S_OPERAND;
                    idx_d   = LAST_IDX;
                    hold_d[NUM_OPS-1] = 1'b0;
                    ops_d[(NUM_OPS-1)*WIDTH +: WIDTH] = '0;
                end else if (trans) begin
                    state_d = S_SHOW;
                    opc_d   = op_in;
                    hold_d[NUM_OPS] = 1'b1;
                    rv_d    = 1'b1;
                end
            end
            S_SHOW: begin
                if (back) begin
                    state_d = S_OPCODE;
                    opc_d   = '0;
                    hold_d[NUM_OPS] = 1'b0;
                    rv_d    = 1'b0;
                end else if (trans || tmr_done) begin
                    wipe = 1'b1;
                end
            end
            seq_state_t'(S_ILLEGAL): begin
                wipe = 1'b1;
            end
        endcase
        if (wipe) begin
            state_d = S_OPERAND;
            idx_d   = '0;
            ops_d   = '0;
            opc_d   = '0;
            hold_d  = '0;
            rv_d    = 1'b0;
        end
    end

    assign operands     = ops_q;
    assign opcode       = opc_q;
    assign state_o      = state_q;
    assign idx_o        = idx_q;
    assign hold         = hold_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_calc_input_seq.sv
// Self-checking bench for calc_input_seq.
// Main instance (2 operands, 8-tick show) plus a 3-operand variant.
module tb_calc_input_seq;

    localparam int N = 2;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        trans = 1'b0, back = 1'b0;
    logic [15:0] data_in = '0;
    logic [1:0]  op_in = '0;
    logic [31:0] operands;
    logic [1:0]  opcode, state_o;
    logic [0:0]  idx_o;
    logic [2:0]  hold;
    logic        result_valid;

    logic        trans3 = 1'b0, back3 = 1'b0;
    logic [15:0] data3 = '0;
    logic [1:0]  op3 = '0;
    logic [47:0] operands3;
    logic [1:0]  opcode3, state3;
    logic [1:0]  idx3;
    logic [3:0]  hold3;
    logic        rv3;

    calc_input_seq #(
        .WIDTH(16), .NUM_OPS(N), .OPCODE_W(2), .SHOW_TICKS(T)
    ) dut (
        .clk(clk), .rst(rst), .trans(trans), .back(back),
        .data_in(data_in), .op_in(op_in), .operands(operands),
        .opcode(opcode), .state_o(state_o), .idx_o(idx_o),
        .hold(hold), .result_valid(result_valid)
    );

    calc_input_seq #(
        .WIDTH(16), .NUM_OPS(3), .OPCODE_W(2), .SHOW_TICKS(0)
    ) dut3 (
        .clk(clk), .rst(rst), .trans(trans3), .back(back3),
        .data_in(data3), .op_in(op3), .operands(operands3),
        .opcode(opcode3), .state_o(state3), .idx_o(idx3),
        .hold(hold3), .result_valid(rv3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: number of captured fields plus stored values.
    int          m_n;
    logic [15:0] m_val [N];
    logic [1:0]  m_op;
    int          m_timer;

    wire [40:0] dut_bus = {state_o, idx_o, hold, operands,
                           opcode, result_valid};

    task automatic model_reset();
        m_n = 0;
        m_op = '0;
        m_timer = 0;
        for (int k = 0; k < N; k++) m_val[k] = '0;
    endtask

    task automatic model_step(input bit tr, input bit bk,
                              input logic [15:0] d,
                              input logic [1:0] op);
        if (bk) begin
            if (m_n == N + 1) begin
                m_op = '0;
                m_n = N;
            end else if (m_n > 0) begin
                m_val[m_n-1] = '0;
                m_n--;
            end
        end else if (tr || (m_n == N + 1 && m_timer == T - 1)) begin
            if (m_n < N) begin
                m_val[m_n] = d;
                m_n++;
            end else if (m_n == N) begin
                m_op = op;
                m_timer = 0;
                m_n++;
            end else begin
                model_reset();
            end
        end else if (m_n == N + 1) begin
            m_timer++;
        end
    endtask

    function automatic logic [40:0] exp_bus();
        logic [1:0] s;
        logic [0:0] i;
        logic [2:0] h;
        s = (m_n < N) ? 2'd0 : ((m_n == N) ? 2'd1 : 2'd2);
        i = (m_n < N) ? 1'(m_n) : 1'(N - 1);
        h = 3'((1 << m_n) - 1);
        return {s, i, h, m_val[1], m_val[0], m_op, (m_n == N + 1)};
    endfunction

    task automatic pulse(input bit tr, input bit bk,
                         input logic [15:0] d, input logic [1:0] op);
        @(negedge clk);
        trans = tr; back = bk; data_in = d; op_in = op;
        @(posedge clk);
        model_step(tr, bk, d, op);
        #1;
        trans = 1'b0; back = 1'b0;
    endtask

    task automatic pulse3(input bit tr, input bit bk,
                          input logic [15:0] d, input logic [1:0] op);
        @(negedge clk);
        trans3 = tr; back3 = bk; data3 = d; op3 = op;
        @(posedge clk);
        #1;
        trans3 = 1'b0; back3 = 1'b0;
    endtask

    task automatic test_reset();
        pulse(1, 0, 16'hBEEF, 2'd0);
        pulse3(1, 0, 16'h7777, 2'd0);
        n_cmp++;
        if (hold !== 3'b001 || hold3 !== 4'b0001) begin
            n_bad++;
            $display("FAIL pre_reset_hold: got %b/%b want 001/0001",
                     hold, hold3);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({state_o, idx_o, hold, operands, opcode, result_valid}
            !== 41'd0) begin
            n_bad++;
            $display("FAIL reset_main: got st=%0d idx=%0d hold=%b ops=%h rv=%b want all 0",
                     state_o, idx_o, hold, operands, result_valid);
        end
        n_cmp++;
        if ({state3, idx3, hold3, operands3, opcode3, rv3} !== 59'd0) begin
            n_bad++;
            $display("FAIL reset_var: got st=%0d hold=%b ops=%h want all 0",
                     state3, hold3, operands3);
        end
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_full_entry();
        pulse(1, 0, 16'h1234, 2'd0);
        pulse(1, 0, 16'h00AB, 2'd0);
        n_cmp++;
        if (state_o !== 2'd1 || hold !== 3'b011) begin
            n_bad++;
            $display("FAIL entry_opcode_phase: got st=%0d hold=%b want 1/011",
                     state_o, hold);
        end
        pulse(1, 0, 16'hFFFF, 2'b10);
        n_cmp++;
        if (operands !== 32'h00AB_1234 || opcode !== 2'd2 ||
            hold !== 3'b111 || state_o !== 2'd2 || result_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL full_entry: got ops=%h opc=%0d hold=%b st=%0d rv=%b want 00ab1234/2/111/2/1",
                     operands, opcode, hold, state_o, result_valid);
        end
        pulse(1, 0, 16'h0, 2'd0);
        n_cmp++;
        if (dut_bus !== exp_bus() || state_o !== 2'd0) begin
            n_bad++;
            $display("FAIL show_exit: got %h want %h", dut_bus, exp_bus());
        end
    endtask

    task automatic test_back();
        pulse(1, 0, 16'h1234, 2'd0);
        pulse(0, 1, 16'h0, 2'd0);
        n_cmp++;
        if (idx_o !== 1'b0 || hold !== 3'b000 || operands[15:0] !== 16'h0) begin
            n_bad++;
            $display("FAIL back_step: got idx=%0d hold=%b op0=%h want 0/000/0000",
                     idx_o, hold, operands[15:0]);
        end
        pulse(0, 1, 16'h0, 2'd0);
        n_cmp++;
        if (dut_bus !== exp_bus() || state_o !== 2'd0 || hold !== 3'b000) begin
            n_bad++;
            $display("FAIL back_at_zero: got %h want %h", dut_bus, exp_bus());
        end
        pulse(1, 0, 16'h5555, 2'd0);
        n_cmp++;
        if (operands[15:0] !== 16'h5555 || idx_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reenter: got op0=%h idx=%0d want 5555/1",
                     operands[15:0], idx_o);
        end
    endtask

    task automatic test_simultaneous();
        pulse(1, 0, 16'h9ABC, 2'd0);
        n_cmp++;
        if (state_o !== 2'd1) begin
            n_bad++;
            $display("FAIL simul_setup: got st=%0d want 1", state_o);
        end
        pulse(1, 1, 16'h0, 2'd3);
        n_cmp++;
        if (state_o !== 2'd0 || idx_o !== 1'b1 || hold !== 3'b001 ||
            opcode !== 2'd0 || dut_bus !== exp_bus()) begin
            n_bad++;
            $display("FAIL simultaneous: got st=%0d idx=%0d hold=%b opc=%0d want 0/1/001/0",
                     state_o, idx_o, hold, opcode);
        end
        pulse(0, 1, 16'h0, 2'd0);
    endtask

    task automatic test_timeout();
        int high;
        pulse(1, 0, 16'($urandom), 2'd0);
        pulse(1, 0, 16'($urandom), 2'd0);
        pulse(1, 0, 16'h0, 2'($urandom));
        n_cmp++;
        if (result_valid !== 1'b1 || dut_bus !== exp_bus()) begin
            n_bad++;
            $display("FAIL timeout_enter: got %h want %h", dut_bus, exp_bus());
        end
        high = 1;
        for (int c = 0; c < 20; c++) begin
            pulse(0, 0, 16'($urandom), 2'($urandom));
            n_cmp++;
            if (dut_bus !== exp_bus()) begin
                n_bad++;
                $display("FAIL timeout_cycle%0d: got %h want %h",
                         c, dut_bus, exp_bus());
            end
            if (result_valid !== 1'b1) break;
            high++;
        end
        n_cmp++;
        if (high !== T || state_o !== 2'd0 || hold !== 3'b000 ||
            operands !== 32'h0) begin
            n_bad++;
            $display("FAIL timeout_len: got %0d cycles st=%0d hold=%b want %0d/0/000",
                     high, state_o, hold, T);
        end
    endtask

    task automatic test_random();
        bit tr, bk;
        logic [15:0] d;
        logic [1:0] op;
        for (int c = 0; c < 500; c++) begin
            tr = ($urandom_range(0, 99) < 40);
            bk = ($urandom_range(0, 99) < 15);
            d  = 16'($urandom);
            op = 2'($urandom);
            pulse(tr, bk, d, op);
            n_cmp++;
            if (dut_bus !== exp_bus()) begin
                n_bad++;
                $display("FAIL random_c%0d: got %h want %h",
                         c, dut_bus, exp_bus());
            end
        end
    endtask

    task automatic test_variant();
        logic [15:0] v [3];
        for (int k = 0; k < 3; k++) v[k] = 16'($urandom);
        pulse3(0, 1, 16'h0, 2'd0);
        for (int k = 0; k < 3; k++) pulse3(1, 0, v[k], 2'd0);
        pulse3(1, 0, 16'h0, 2'd1);
        n_cmp++;
        if (hold3 !== 4'b1111 || state3 !== 2'd2 || rv3 !== 1'b1 ||
            operands3 !== {v[2], v[1], v[0]} || opcode3 !== 2'd1) begin
            n_bad++;
            $display("FAIL var_entry: got hold=%b st=%0d ops=%h opc=%0d want 1111/2/%h/1",
                     hold3, state3, operands3, opcode3, {v[2], v[1], v[0]});
        end
        repeat (100) pulse3(0, 0, 16'($urandom), 2'($urandom));
        n_cmp++;
        if (state3 !== 2'd2 || rv3 !== 1'b1 || hold3 !== 4'b1111) begin
            n_bad++;
            $display("FAIL var_no_timeout: got st=%0d rv=%b want 2/1",
                     state3, rv3);
        end
        pulse3(1, 0, 16'h0, 2'd0);
        n_cmp++;
        if (state3 !== 2'd0 || idx3 !== 2'd0 || hold3 !== 4'b0000 ||
            operands3 !== 48'h0 || opcode3 !== 2'd0 || rv3 !== 1'b0) begin
            n_bad++;
            $display("FAIL var_exit: got st=%0d idx=%0d hold=%b ops=%h want 0/0/0000/0",
                     state3, idx3, hold3, operands3);
        end
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #10;
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_full_entry();
        test_back();
        test_simultaneous();
        test_timeout();
        test_random();
        test_variant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_input_seq.md
Name: calc_input_seq

Overview:
Parametrised operand/opcode entry sequencer for the calculator datapath. It advances on one-cycle `trans` pulses and steps backwards on `back` pulses. It captures N operands and one opcode into registers, and publishes a thermometer-coded hold mask plus state for the display mux and ALU. In the result phase it can optionally time out and return to operand entry.

Parameters:
- WIDTH, 16, operand width in bits.
- NUM_OPS, 2, number of operands to capture (legal range 1..4).
- OPCODE_W, 2, opcode width in bits.
- SHOW_TICKS, 0, number of clk cycles the result phase lasts before auto-return; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- trans  in  1  advance pulse (already debounced, one cycle wide).
- back  in  1  step-back pulse (already debounced, one cycle wide).
- data_in  in  WIDTH  operand value to capture.
- op_in  in  OPCODE_W  opcode value to capture.
- operands  out  NUM_OPS*WIDTH  captured operands; operand k sits at bits [k*WIDTH +: WIDTH].
- opcode  out  OPCODE_W  captured opcode.
- state_o  out  2  current seq_state_t value.
- idx_o  out  IDX_W  operand index being entered; IDX_W = max(1, clog2(NUM_OPS)).
- hold  out  NUM_OPS+1  thermometer mask of captured fields; bit k is operand k, bit NUM_OPS is the opcode.
- result_valid  out  1  high while in S_SHOW.

Behaviour:
- All outputs are registered. An input sampled on a rising edge is reflected in the outputs after that same edge, i.e. 1-cycle latency.
- Reset (asynchronous, takes effect immediately with no clock edge needed):
  - state S_OPERAND, idx 0;
  - operands 0, opcode 0, hold 0;
  - result_valid 0, timer 0.
- Priority: when trans and back are both high in the same cycle, back wins and trans is ignored.
- S_OPERAND, index k:
  - trans: operand[k] <= data_in and hold[k] <= 1. If k < NUM_OPS-1, idx goes to k+1; otherwise go to S_OPCODE.
  - back, k > 0: idx goes to k-1; hold[k-1] <= 0 and operand[k-1] <= 0.
  - back, k = 0: no effect.
- S_OPCODE:
  - trans: opcode <= op_in, hold[NUM_OPS] <= 1, go to S_SHOW, result_valid <= 1, timer <= 0.
  - back: go to S_OPERAND with idx NUM_OPS-1; clear hold[NUM_OPS-1] and operand[NUM_OPS-1].
- S_SHOW:
  - trans: go to S_OPERAND, idx 0; clear all of hold, operands and opcode; result_valid <= 0.
  - back: go to S_OPCODE; hold[NUM_OPS] <= 0, opcode <= 0, result_valid <= 0.
  - Timeout (SHOW_TICKS > 0, no trans or back): timer increments every cycle. On the edge where timer == SHOW_TICKS-1, perform the same action as trans. S_SHOW therefore lasts exactly SHOW_TICKS cycles.
  - SHOW_TICKS = 0: the timer is held at 0 and S_SHOW is left only by trans or back.
- Idle inputs: with neither trans nor back high, all registers hold their value, except the timer in S_SHOW.
- Invariant: hold is always a thermometer code. hold == (1 << captured_fields) - 1, where captured_fields = k in S_OPERAND idx k, NUM_OPS in S_OPCODE, and NUM_OPS+1 in S_SHOW.
- data_in and op_in are sampled only on a qualifying trans edge; they are don't-care otherwise.
- Unreachable state encoding 2'd3 recovers to S_OPERAND idx 0 with all registers cleared.
- Elaboration-time check: NUM_OPS outside 1..4 is an elaboration error.

Decomposition:
- Package calc_pkg holds:
  - typedef enum logic [1:0] seq_state_t, with S_OPERAND=0, S_OPCODE=1, S_SHOW=2;
  - the illegal-encoding constant S_ILLEGAL=3, used by the recovery case.
- One sub-module, show_timer:
  - parameter TICKS; inputs clk, rst, clr, en; output done;
  - counter width clog2(TICKS+1);
  - done is tied to 0 when TICKS = 0.
- The FSM and the capture registers stay in calc_input_seq.

Test Plan:
- Bench parameters unless stated: WIDTH=16, NUM_OPS=2, SHOW_TICKS=8.
- Reset check: assert rst mid-cycle with no clock edge -> state_o=0, idx_o=0, hold=3'b000, operands=0, result_valid=0 immediately.
- Full entry: data_in=16'h1234 + trans, then 16'h00AB + trans, then op_in=2'b10 + trans -> operands={16'h00AB,16'h1234}, opcode=2, hold=3'b111, state_o=2, result_valid=1 one cycle after the third trans.
- Back stepping: capture 16'h1234, then back -> idx_o=0, hold=3'b000, operand0=0. Back again at idx 0 -> no change. Re-enter 16'h5555 -> operand0=16'h5555.
- Timeout: reach S_SHOW, then hold inputs idle -> result_valid high for exactly 8 cycles; then state_o=0, hold=0, operands=0.
- Simultaneous pulses: in S_OPCODE, pulse trans and back together -> state_o=0, idx_o=1, hold=3'b001, opcode unchanged at 0.
- Variant NUM_OPS=3, SHOW_TICKS=0: enter 3 operands and an opcode -> hold=4'b1111. Idle 100 cycles -> still in S_SHOW. Then trans -> back to S_OPERAND idx 0 with hold=0.
